// File: rtl/muldiv_iter_pkg.sv
// Shared opcode constants and FSM state type for the iterative multiply/divide unit.
package muldiv_iter_pkg;

   localparam logic [4:0] OPMUL    = 5'd0;
   localparam logic [4:0] OPMULH   = 5'd1;
   localparam logic [4:0] OPMULHSU = 5'd2;
   localparam logic [4:0] OPMULHU  = 5'd3;
   localparam logic [4:0] OPDIV    = 5'd4;
   localparam logic [4:0] OPDIVU   = 5'd5;
   localparam logic [4:0] OPREM    = 5'd6;
   localparam logic [4:0] OPREMU   = 5'd7;

   localparam logic [63:0] ZERO = 64'd0;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider sharing one 2*XLEN shift register
// and one (XLEN+1)-bit adder; sign handling is done on magnitudes.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iStart,
   input  logic [4:0]      iControl,
   input  logic [XLEN-1:0] iA,
   input  logic [XLEN-1:0] iB,
   output logic [XLEN-1:0] oResult,
   output logic            oBusy,
   output logic            oDone
);
   localparam int CW = $clog2(XLEN);

   state_t            state, state_nxt;
   logic [4:0]        op_r;
   logic [XLEN-1:0]   b_r;
   logic              neg_r;
   logic [2*XLEN-1:0] acc, acc_nxt;
   logic [CW-1:0]     cnt;
   logic              last;

   logic              a_sgn, b_sgn, is_div, b_zero, ovf, bypass, neg_in;
   logic [XLEN-1:0]   a_mag, b_mag, byp_res;

   // Accept-time decode, evaluated straight from the live inputs.
   always_comb begin
      is_div  = iControl inside {OPDIV, OPDIVU, OPREM, OPREMU};
      a_sgn   = iA[XLEN-1] & (iControl inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM});
      b_sgn   = iB[XLEN-1] & (iControl inside {OPMUL, OPMULH, OPDIV, OPREM});
      a_mag   = a_sgn ? -iA : iA;
      b_mag   = b_sgn ? -iB : iB;
      b_zero  = (iB == '0);
      ovf     = (iControl inside {OPDIV, OPREM}) && (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
      bypass  = !(iControl inside {OPMUL, OPMULH, OPMULHSU, OPMULHU}) && !(is_div && !b_zero && !ovf);
      neg_in  = (iControl == OPREM) ? a_sgn : (a_sgn ^ b_sgn);
      byp_res = ZERO;
      if (is_div && b_zero)
         byp_res = (iControl inside {OPDIV, OPDIVU}) ? '1 : iA;
      else if (ovf)
         byp_res = (iControl == OPDIV) ? iA : ZERO;
   end

   logic              div_r;
   logic [XLEN:0]     add_a, add_b, sum;
   logic [2*XLEN-1:0] neg_full;
   logic [XLEN-1:0]   neg_lo, neg_hi, calc_res;

   // One iteration: multiply adds into the high half and shifts right;
   // divide trial-subtracts from the shifted-in remainder and shifts left.
   always_comb begin
      div_r = op_r inside {OPDIV, OPDIVU, OPREM, OPREMU};
      if (div_r) begin
         add_a = acc[2*XLEN-1:XLEN-1];
         add_b = ~{1'b0, b_r};
      end else begin
         add_a = {1'b0, acc[2*XLEN-1:XLEN]};
         add_b = {1'b0, b_r};
      end
      sum = add_a + add_b + {{XLEN{1'b0}}, div_r};
      if (div_r)
         acc_nxt = sum[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                             : {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nxt = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

      neg_full = -acc_nxt;
      neg_lo   = -acc_nxt[XLEN-1:0];
      neg_hi   = -acc_nxt[2*XLEN-1:XLEN];
      case (op_r)
         OPMUL:                      calc_res = neg_r ? neg_full[XLEN-1:0] : acc_nxt[XLEN-1:0];
         OPMULH, OPMULHSU, OPMULHU:  calc_res = neg_r ? neg_full[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
         OPDIV, OPDIVU:              calc_res = neg_r ? neg_lo : acc_nxt[XLEN-1:0];
         default:                    calc_res = neg_r ? neg_hi : acc_nxt[2*XLEN-1:XLEN];
      endcase
   end

   assign last  = (cnt == CW'(XLEN-1));
   assign oBusy = (state != IDLE);
   assign oDone = (state == FIN);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (iStart) state_nxt = bypass ? FIN : CALC;
         CALC:    if (last)   state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         op_r    <= '0;
         b_r     <= '0;
         neg_r   <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         oResult <= '0;
      end else if (state == IDLE && iStart) begin
         op_r  <= iControl;
         b_r   <= b_mag;
         neg_r <= neg_in;
         acc   <= {{XLEN{1'b0}}, a_mag};
         cnt   <= '0;
         if (bypass) oResult <= byp_res;
      end else if (state == CALC) begin
         acc <= acc_nxt;
         cnt <= cnt + 1'b1;
         if (last) oResult <= calc_res;
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboarded, table-driven bench for muldiv_iter plus latching, abort and random sequences.
module tb_muldiv_iter;
   import muldiv_iter_pkg::*;

   logic        iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0;
   logic [4:0]  iControl = '0;
   logic [63:0] iA = '0, iB = '0;
   logic [63:0] oResult;
   logic        oBusy, oDone;

   muldiv_iter #(.XLEN(64)) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iControl(iControl),
      .iA(iA), .iB(iB), .oResult(oResult), .oBusy(oBusy), .oDone(oDone)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      string       nm;
      logic [4:0]  op;
      logic [63:0] a, b, exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [63:0] exp;
      int          lat;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[$];
   int   n_cmp = 0, n_bad = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Drive one request, then follow it to oDone; pulse_at > 0 injects a stray iStart mid-CALC.
   task automatic run_op(input string nm, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input int pulse_at);
      sb_t e;
      int  n, busy;
      @(negedge iCLK);
      iControl = op; iA = a; iB = b; iStart = 1'b1;
      sb.push_back('{exp, lat});
      @(negedge iCLK);
      iStart = 1'b0; iA = ~a; iB = b ^ 64'h5A; iControl = OPMULHU;
      n = 1; busy = 0;
      while (!oDone && n < 200) begin
         if (oBusy) busy++;
         if (n == pulse_at) begin
            iStart = 1'b1; iA = 64'h1111; iB = 64'h3; iControl = OPMUL;
         end else
            iStart = 1'b0;
         @(negedge iCLK);
         n++;
      end
      iStart = 1'b0;
      if (oBusy) busy++;
      e = sb.pop_front();
      check({nm, " result"},  oResult,  e.exp);
      check({nm, " latency"}, 64'(n),    64'(e.lat));
      check({nm, " busy"},    64'(busy), 64'(e.lat));
      @(negedge iCLK);
      check({nm, " done/busy drop"}, {62'd0, oDone, oBusy}, 64'd0);
      check({nm, " hold"}, oResult, e.exp);
   endtask

   initial begin
      logic [63:0]  ra, rb;
      logic [127:0] p;
      sb_t          dropped;

      vecs.push_back('{"mul -3*7",      OPMUL,    -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65});
      vecs.push_back('{"mulhu max",     OPMULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
      vecs.push_back('{"mulh -1*-1",    OPMULH,   '1, '1, 64'd0, 65});
      vecs.push_back('{"mulhsu -1*2",   OPMULHSU, '1, 64'd2, '1, 65});
      vecs.push_back('{"mulhu 2^63*4",  OPMULHU,  64'h8000_0000_0000_0000, 64'd4, 64'd2, 65});
      vecs.push_back('{"mul big",       OPMUL,    64'h1_2345_6789, 64'h1000, 64'h1234_5678_9000, 65});
      vecs.push_back('{"div -7/2",      OPDIV,    -64'sd7, 64'd2, -64'sd3, 65});
      vecs.push_back('{"rem -7%2",      OPREM,    -64'sd7, 64'd2, '1, 65});
      vecs.push_back('{"divu 7/2",      OPDIVU,   64'd7, 64'd2, 64'd3, 65});
      vecs.push_back('{"div 100/-7",    OPDIV,    64'd100, -64'sd7, -64'sd14, 65});
      vecs.push_back('{"rem 100%-7",    OPREM,    64'd100, -64'sd7, 64'd2, 65});
      vecs.push_back('{"remu 100%7",    OPREMU,   64'd100, 64'd7, 64'd2, 65});
      vecs.push_back('{"divu x/0",      OPDIVU,   64'd5, 64'd0, '1, 1});
      vecs.push_back('{"rem 5%0",       OPREM,    64'd5, 64'd0, 64'd5, 1});
      vecs.push_back('{"div ovf",       OPDIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
      vecs.push_back('{"rem ovf",       OPREM,    64'h8000_0000_0000_0000, '1, 64'd0, 1});
      vecs.push_back('{"bad opcode",    5'd9,     64'd5, 64'd3, 64'd0, 1});

      #2 iRST = 1'b0;
      #10;
      check("reset result", oResult, 64'd0);
      check("reset busy/done", {62'd0, oBusy, oDone}, 64'd0);
      @(negedge iCLK);
      iRST = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

      // Stray iStart in CALC cycle 10 must neither change the result nor queue a second op.
      run_op("mul stray start", OPMUL, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65, 10);
      check("no queued op", {63'd0, oBusy}, 64'd0);

      // Abort at CALC cycle 30; oResult still holds the previous nonzero result here.
      @(negedge iCLK);
      iControl = OPMUL; iA = 64'd5; iB = 64'd5; iStart = 1'b1;
      sb.push_back('{64'd25, 65});
      @(negedge iCLK);
      iStart = 1'b0;
      repeat (29) @(negedge iCLK);
      iRST = 1'b0;
      #1;
      check("abort result", oResult, 64'd0);
      check("abort busy/done", {62'd0, oBusy, oDone}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge iCLK);
         check("abort no done", {63'd0, oDone}, 64'd0);
      end
      dropped = sb.pop_front();
      iRST = 1'b1;
      run_op("after abort", OPMUL, 64'd5, 64'd5, 64'd25, 65, 0);

      for (int k = 0; k < 4; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(0, 60);
         if (rb == 0) rb = 64'd3;
         p = {64'd0, ra} * {64'd0, rb};
         run_op("rand mulhu", OPMULHU, ra, rb, p[127:64], 65, 0);
         run_op("rand mul",   OPMUL,   ra, rb, p[63:0], 65, 0);
         run_op("rand divu",  OPDIVU,  ra, rb, ra / rb, 65, 0);
         run_op("rand remu",  OPREMU,  ra, rb, ra % rb, 65, 0);
         run_op("rand div",   OPDIV,   ra, rb, 64'($signed(ra) / $signed(rb)), 65, 0);
         run_op("rand rem",   OPREM,   ra, rb, 64'($signed(ra) % $signed(rb)), 65, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
